// File: rtl/cpc_bus_initiator_if.sv
// Command port and CPC expansion bus pins of the bus-cycle initiator.
// The master modport is the initiator side; slave is the controller/bus side.
interface cpc_bus_initiator_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_adr;
    logic [7:0]  cmd_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic [15:0] adr;
    logic [7:0]  data_out;
    logic        data_oe;
    logic [7:0]  data_in;
    logic        mreq_b;
    logic        iorq_b;
    logic        rd_b;
    logic        wr_b;
    logic        m1_b;
    logic        rfsh_b;
    logic        ready;

    modport master (
        input  cmd_valid, cmd_op, cmd_adr, cmd_wdata, data_in, ready,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, adr, data_out, data_oe,
               mreq_b, iorq_b, rd_b, wr_b, m1_b, rfsh_b
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_adr, cmd_wdata, data_in, ready,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, adr, data_out, data_oe,
               mreq_b, iorq_b, rd_b, wr_b, m1_b, rfsh_b
    );
endinterface

// File: rtl/cpc_bus_initiator.sv
// Z80-style bus-cycle initiator: one command in, one phased memory or I/O
// cycle out on the CPC expansion bus, with READY wait-state stretching and
// a wait timeout. clk runs at twice the T-state rate (A/B half-states).
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// T1A   | address driven, strobes high
// T1B   | memory: MREQ (+RD) low; writes: data bus enabled
// T2A   | memory write: WR low; I/O: IORQ + RD/WR low
// T2B   | memory: READY sampled at exit; I/O: always into mandatory TW
// TWA   | wait state, first half
// TWB   | wait state, second half; READY sampled at exit
// T3A   | strobes held; read data captured at exit
// T3B   | strobes released, write data still driven for hold
module cpc_bus_initiator #(
    parameter int WAIT_MAX = 255
) (
    input  logic                   clk,
    input  logic                   reset_b,
    cpc_bus_initiator_if.master    bus
);
    localparam logic [7:0] WAIT_LIM = 8'(WAIT_MAX);

    typedef enum logic [3:0] {
        IDLE, T1A, T1B, T2A, T2B, TWA, TWB, T3A, T3B
    } state_t;

    state_t      state, state_nx;
    logic [1:0]  op;
    logic [7:0]  wait_cnt, wait_cnt_nx;
    logic        mand_tw, mand_tw_nx;
    logic        abort, abort_nx;
    logic        accept;
    logic        is_io, is_wr;

    logic        cmd_ready_q, rsp_valid_q, rsp_err_q;
    logic [7:0]  rsp_rdata_q;
    logic [15:0] adr_q;
    logic [7:0]  data_out_q;
    logic        data_oe_q, mreq_b_q, iorq_b_q, rd_b_q, wr_b_q;

    logic        in_strobe, in_late;
    logic        data_oe_nx, mreq_b_nx, iorq_b_nx, rd_b_nx, wr_b_nx;

    assign is_io  = op[1];
    assign is_wr  = op[0];
    assign accept = bus.cmd_valid && cmd_ready_q;

    // Next-state logic; the wait counter only counts READY-requested waits,
    // never the mandatory I/O wait state.
    always_comb begin
        state_nx    = state;
        wait_cnt_nx = wait_cnt;
        mand_tw_nx  = mand_tw;
        abort_nx    = abort;
        case (state)
            IDLE: if (accept) state_nx = T1A;
            T1A: begin
                state_nx    = T1B;
                wait_cnt_nx = '0;
                mand_tw_nx  = 1'b0;
                abort_nx    = 1'b0;
            end
            T1B: state_nx = T2A;
            T2A: state_nx = T2B;
            T2B: begin
                if (is_io) begin
                    state_nx   = TWA;
                    mand_tw_nx = 1'b1;
                end else if (!bus.ready) begin
                    state_nx   = TWA;
                    mand_tw_nx = 1'b0;
                end else begin
                    state_nx = T3A;
                end
            end
            TWA: state_nx = TWB;
            TWB: begin
                if (bus.ready) begin
                    state_nx = T3A;
                end else begin
                    mand_tw_nx = 1'b0;
                    if (mand_tw) begin
                        state_nx = TWA;
                    end else begin
                        wait_cnt_nx = wait_cnt + 8'd1;
                        if (wait_cnt + 8'd1 == WAIT_LIM) begin
                            state_nx = T3B;
                            abort_nx = 1'b1;
                        end else begin
                            state_nx = TWA;
                        end
                    end
                end
            end
            T3A: state_nx = T3B;
            T3B: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Bus outputs decoded from the next state so the registered pins are glitch-free.
    always_comb begin
        in_strobe  = state_nx inside {T1B, T2A, T2B, TWA, TWB, T3A};
        in_late    = state_nx inside {T2A, T2B, TWA, TWB, T3A};
        mreq_b_nx  = !(!is_io && in_strobe);
        iorq_b_nx  = !(is_io && in_late);
        rd_b_nx    = !(!is_wr && (is_io ? in_late : in_strobe));
        wr_b_nx    = !(is_wr && in_late);
        data_oe_nx = is_wr && (in_strobe || state_nx == T3B);
    end

    // FSM state and cycle bookkeeping.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state    <= IDLE;
            wait_cnt <= '0;
            mand_tw  <= 1'b0;
            abort    <= 1'b0;
            op       <= 2'b00;
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_cnt_nx;
            mand_tw  <= mand_tw_nx;
            abort    <= abort_nx;
            if (accept) op <= bus.cmd_op;
        end
    end

    // Registered bus pins, command latch and response port.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            mreq_b_q    <= 1'b1;
            iorq_b_q    <= 1'b1;
            rd_b_q      <= 1'b1;
            wr_b_q      <= 1'b1;
            data_oe_q   <= 1'b0;
            adr_q       <= '0;
            data_out_q  <= '0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            mreq_b_q    <= mreq_b_nx;
            iorq_b_q    <= iorq_b_nx;
            rd_b_q      <= rd_b_nx;
            wr_b_q      <= wr_b_nx;
            data_oe_q   <= data_oe_nx;
            cmd_ready_q <= (state_nx == IDLE);
            rsp_valid_q <= (state == T3B);
            rsp_err_q   <= (state == T3B) && abort;
            if (accept) begin
                adr_q <= bus.cmd_adr;
                if (bus.cmd_op[0]) data_out_q <= bus.cmd_wdata;
            end
            if (state == T3A && !is_wr) rsp_rdata_q <= bus.data_in;
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.adr       = adr_q;
    assign bus.data_out  = data_out_q;
    assign bus.data_oe   = data_oe_q;
    assign bus.mreq_b    = mreq_b_q;
    assign bus.iorq_b    = iorq_b_q;
    assign bus.rd_b      = rd_b_q;
    assign bus.wr_b      = wr_b_q;
    assign bus.m1_b      = 1'b1;
    assign bus.rfsh_b    = 1'b1;
endmodule

// File: tb/tb_cpc_bus_initiator.sv
// Directed bench for cpc_bus_initiator: a table of single bus cycles with
// hand-computed phase lengths, plus reset and back-to-back sequences.
module tb_cpc_bus_initiator;
    logic clk = 1'b0;
    logic reset_b = 1'b0;

    always #5 clk = ~clk;

    cpc_bus_initiator_if bus();

    cpc_bus_initiator #(.WAIT_MAX(4)) dut (
        .clk     (clk),
        .reset_b (reset_b),
        .bus     (bus)
    );

    typedef struct {
        logic [1:0]  op;
        logic [15:0] adr;
        logic [7:0]  wdata;
        logic [7:0]  din;
        int          hi_at;    // first period (T1A = 1) in which READY is driven high
        int          lat;      // period in which rsp_valid is seen
        int          mreq_lo;
        int          iorq_lo;
        int          rd_lo;
        int          wr_lo;
        int          oe_hi;
        bit          err;
    } vec_t;

    localparam logic [6:0] IDLE_PINS = 7'b1111110; // mreq iorq rd wr m1 rfsh oe

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_rdata = 8'h00;
    vec_t       vecs[10];
    vec_t       b2b[3];

    function automatic logic [6:0] pins();
        return {bus.mreq_b, bus.iorq_b, bus.rd_b, bus.wr_b, bus.m1_b, bus.rfsh_b, bus.data_oe};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(bus.cmd_ready), 32'd1);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int lat, mreq_lo, iorq_lo, rd_lo, wr_lo, oe_hi;
        int bad_adr, bad_dout, bad_rdy, overlap, bad_const;
        lat = 0; mreq_lo = 0; iorq_lo = 0; rd_lo = 0; wr_lo = 0; oe_hi = 0;
        bad_adr = 0; bad_dout = 0; bad_rdy = 0; overlap = 0; bad_const = 0;
        wait_ready($sformatf("v%0d_ready", idx));
        bus.cmd_op    = v.op;
        bus.cmd_adr   = v.adr;
        bus.cmd_wdata = v.wdata;
        bus.data_in   = v.din;
        bus.ready     = 1'b0;
        bus.cmd_valid = 1'b1;
        for (int p = 1; p <= 300; p++) begin
            @(negedge clk);
            if (bus.rsp_valid === 1'b1) begin
                lat = p;
                break;
            end
            if (bus.mreq_b === 1'b0) mreq_lo++;
            if (bus.iorq_b === 1'b0) iorq_lo++;
            if (bus.rd_b === 1'b0) rd_lo++;
            if (bus.wr_b === 1'b0) wr_lo++;
            if (bus.data_oe === 1'b1) begin
                oe_hi++;
                if (bus.data_out !== v.wdata) bad_dout++;
            end
            if (bus.adr !== v.adr) bad_adr++;
            if (bus.cmd_ready !== 1'b0) bad_rdy++;
            if (bus.rd_b === 1'b0 && bus.wr_b === 1'b0) overlap++;
            if (bus.m1_b !== 1'b1 || bus.rfsh_b !== 1'b1) bad_const++;
            if (p == 1) begin
                // command port scrambled after accept: must not disturb the cycle
                bus.cmd_valid = 1'b0;
                bus.cmd_op    = ~v.op;
                bus.cmd_adr   = ~v.adr;
                bus.cmd_wdata = ~v.wdata;
            end
            bus.ready = (p >= v.hi_at);
        end
        bus.cmd_valid = 1'b0;
        if (!v.err && !v.op[0]) exp_rdata = v.din;
        check($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.lat));
        check($sformatf("v%0d_mreq_lo", idx), 32'(mreq_lo), 32'(v.mreq_lo));
        check($sformatf("v%0d_iorq_lo", idx), 32'(iorq_lo), 32'(v.iorq_lo));
        check($sformatf("v%0d_rd_lo", idx), 32'(rd_lo), 32'(v.rd_lo));
        check($sformatf("v%0d_wr_lo", idx), 32'(wr_lo), 32'(v.wr_lo));
        check($sformatf("v%0d_oe_hi", idx), 32'(oe_hi), 32'(v.oe_hi));
        check($sformatf("v%0d_data_out", idx), 32'(bad_dout), 32'd0);
        check($sformatf("v%0d_adr_hold", idx), 32'(bad_adr), 32'd0);
        check($sformatf("v%0d_ready_busy", idx), 32'(bad_rdy), 32'd0);
        check($sformatf("v%0d_rd_wr_overlap", idx), 32'(overlap), 32'd0);
        check($sformatf("v%0d_m1_rfsh", idx), 32'(bad_const), 32'd0);
        check($sformatf("v%0d_rsp_err", idx), 32'(bus.rsp_err), 32'(v.err));
        check($sformatf("v%0d_rsp_rdata", idx), 32'(bus.rsp_rdata), 32'(exp_rdata));
        check($sformatf("v%0d_rsp_pins", idx), 32'(pins()), 32'(IDLE_PINS));
        check($sformatf("v%0d_rsp_ready", idx), 32'(bus.cmd_ready), 32'd1);
        @(negedge clk);
        check($sformatf("v%0d_rsp_pulse", idx), 32'(bus.rsp_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad, acc_n, last_acc, rsp_cnt, overlap, bad_idle;
        bit pending, done;

        //            op     adr       wdata  din    hi   lat mreq iorq rd  wr  oe  err
        vecs[0] = '{2'b00, 16'h4000, 8'h00, 8'hA5,   1,   7,  4,  0,  4,  0,  0, 1'b0};
        vecs[1] = '{2'b01, 16'h8001, 8'h3C, 8'h00,   1,   7,  4,  0,  0,  3,  5, 1'b0};
        vecs[2] = '{2'b11, 16'h7F00, 8'hC2, 8'h00,   1,   9,  0,  5,  0,  5,  7, 1'b0};
        vecs[3] = '{2'b10, 16'h7E12, 8'h00, 8'h5B,   1,   9,  0,  5,  5,  0,  0, 1'b0};
        vecs[4] = '{2'b01, 16'hC000, 8'h96, 8'h00,   8,  11,  8,  0,  0,  7,  9, 1'b0};
        vecs[5] = '{2'b00, 16'h0FFF, 8'h00, 8'h3E,  12,  15, 12,  0, 12,  0,  0, 1'b0};
        vecs[6] = '{2'b11, 16'h7FFF, 8'h81, 8'h00,   8,  11,  0,  7,  0,  7,  9, 1'b0};
        vecs[7] = '{2'b00, 16'h2222, 8'h00, 8'h77, 999,  14, 11,  0, 11,  0,  0, 1'b1};
        vecs[8] = '{2'b10, 16'h1234, 8'h00, 8'h99, 999,  16,  0, 12, 12,  0,  0, 1'b1};
        vecs[9] = '{2'b01, 16'h5555, 8'h0F, 8'h00, 999,  14, 11,  0,  0, 10, 12, 1'b1};

        b2b[0] = '{2'b01, 16'h7F10, 8'hE4, 8'h6C, 1, 7, 4, 0, 0, 3, 5, 1'b0};
        b2b[1] = '{2'b10, 16'h7E20, 8'h00, 8'h6C, 1, 9, 0, 5, 5, 0, 0, 1'b0};
        b2b[2] = '{2'b00, 16'h9000, 8'h00, 8'h6C, 1, 7, 4, 0, 4, 0, 0, 1'b0};

        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_adr   = 16'h0000;
        bus.cmd_wdata = 8'h00;
        bus.data_in   = 8'h00;
        bus.ready     = 1'b1;

        // power-up reset values
        @(negedge clk);
        check("rst_pins", 32'(pins()), 32'(IDLE_PINS));
        check("rst_adr", 32'(bus.adr), 32'd0);
        check("rst_data_out", 32'(bus.data_out), 32'd0);
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        check("rst_rsp", 32'({bus.rsp_valid, bus.rsp_err}), 32'd0);
        check("rst_rdata", 32'(bus.rsp_rdata), 32'd0);
        reset_b = 1'b1;
        @(negedge clk);
        check("rel_cmd_ready", 32'(bus.cmd_ready), 32'd1);

        for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

        // reset during the mandatory wait state of an I/O write
        wait_ready("mid_ready");
        bus.cmd_op    = 2'b11;
        bus.cmd_adr   = 16'h7F40;
        bus.cmd_wdata = 8'h5A;
        bus.ready     = 1'b0;
        bus.cmd_valid = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_iorq_active", 32'({bus.iorq_b, bus.wr_b, bus.data_oe}), 32'b001);
        #2 reset_b = 1'b0;
        #1;
        check("mid_rst_pins", 32'(pins()), 32'(IDLE_PINS));
        check("mid_rst_adr", 32'(bus.adr), 32'd0);
        check("mid_rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b0) bad++;
        end
        reset_b = 1'b1;
        bus.ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b0) bad++;
        end
        check("mid_no_rsp", 32'(bad), 32'd0);
        exp_rdata = 8'h00;
        check("mid_rdata_cleared", 32'(bus.rsp_rdata), 32'd0);
        run_vec(100, vecs[0]);

        // three commands back to back with cmd_valid held high
        bus.ready   = 1'b1;
        bus.data_in = 8'h6C;
        wait_ready("b2b_ready");
        bus.cmd_op    = b2b[0].op;
        bus.cmd_adr   = b2b[0].adr;
        bus.cmd_wdata = b2b[0].wdata;
        bus.cmd_valid = 1'b1;
        acc_n = 0; last_acc = 0; rsp_cnt = 0; overlap = 0; bad_idle = 0;
        pending = 1'b0; done = 1'b0;
        for (int t = 0; t < 80; t++) begin
            if (t > 0) @(negedge clk);
            if (bus.rd_b === 1'b0 && bus.wr_b === 1'b0) overlap++;
            if (bus.rsp_valid === 1'b1) begin
                rsp_cnt++;
                if (bus.cmd_ready !== 1'b1) bad_idle++;
            end
            if (bus.cmd_ready === 1'b1) begin
                if (pins() !== IDLE_PINS) bad_idle++;
                if (acc_n > 0) begin
                    check($sformatf("b2b_gap%0d", acc_n), 32'(t - last_acc), 32'(b2b[acc_n-1].lat));
                    check($sformatf("b2b_rsp%0d", acc_n), 32'(bus.rsp_valid), 32'd1);
                end
                if (acc_n == 3) begin
                    done = 1'b1;
                    break;
                end
                last_acc = t;
                acc_n++;
                pending = 1'b1;
            end else if (pending) begin
                pending = 1'b0;
                if (acc_n < 3) begin
                    bus.cmd_op    = b2b[acc_n].op;
                    bus.cmd_adr   = b2b[acc_n].adr;
                    bus.cmd_wdata = b2b[acc_n].wdata;
                end else begin
                    bus.cmd_valid = 1'b0;
                end
            end
        end
        bus.cmd_valid = 1'b0;
        check("b2b_done", 32'(done), 32'd1);
        check("b2b_rsp_count", 32'(rsp_cnt), 32'd3);
        check("b2b_overlap", 32'(overlap), 32'd0);
        check("b2b_idle_only", 32'(bad_idle), 32'd0);
        check("b2b_rdata", 32'(bus.rsp_rdata), 32'h6C);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
